// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants and request record for the SRAM port arbiter.
// Source ids double as the order-FIFO payload.
package sram_port_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam int OUTSTANDING_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/sram_port_arbiter_fifo.sv
// In-order source-id FIFO; push/pop take effect at the clock edge, head is combinational.
// Push ignored when full, pop ignored when empty; simultaneous push/pop keeps occupancy.
module arb_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_dat,
  input  logic pop,
  output logic pop_dat,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter onto one SRAM-like port; zero added latency on request and response paths.
// Unaccepted requests are locked until mem_addr_ok; full order FIFO blocks mem_req. Macro SRAM_ARB_RR_EN selects round-robin.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int OUTSTANDING_DEPTH = OUTSTANDING_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_spurious
);

  mem_req_t inst_fields, data_fields, req_fields, lock_fields_q;
  logic     lock_q, lock_src_q;
  logic     sel_src, grant_src, req_pending;
  logic     accept, pop, head_src, fifo_full, fifo_empty;
`ifdef SRAM_ARB_RR_EN
  logic     prio_q;
`endif

  always_comb begin
    inst_fields = '{wr: 1'b0, size: SIZE_WORD, addr: inst_addr, wstrb: 4'h0, wdata: 32'h0};
    data_fields = '{wr: data_wr, size: data_size, addr: data_addr,
                    wstrb: data_wstrb, wdata: data_wdata};
`ifdef SRAM_ARB_RR_EN
    if (inst_req && data_req) sel_src = prio_q;
    else                      sel_src = data_req ? SRC_DATA : SRC_INST;
`else
    sel_src = data_req ? SRC_DATA : SRC_INST;
`endif
    // A stalled request keeps its source and fields even if the requester's bus changes.
    if (lock_q) begin
      grant_src   = lock_src_q;
      req_fields  = lock_fields_q;
      req_pending = 1'b1;
    end else begin
      grant_src   = sel_src;
      req_fields  = (sel_src == SRC_DATA) ? data_fields : inst_fields;
      req_pending = inst_req | data_req;
    end
  end

  assign mem_req      = req_pending & ~fifo_full & ~reset;
  assign accept       = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept & (grant_src == SRC_INST);
  assign data_addr_ok = accept & (grant_src == SRC_DATA);

  assign mem_wr    = req_fields.wr;
  assign mem_size  = req_fields.size;
  assign mem_addr  = req_fields.addr;
  assign mem_wstrb = req_fields.wstrb;
  assign mem_wdata = req_fields.wdata;

  assign pop          = mem_data_ok & ~fifo_empty & ~reset;
  assign inst_data_ok = pop & (head_src == SRC_INST);
  assign data_data_ok = pop & (head_src == SRC_DATA);
  assign rdata        = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= 1'b0;
    end else if (accept) begin
      lock_q <= 1'b0;
    end else if (mem_req) begin
      lock_q        <= 1'b1;
      lock_src_q    <= grant_src;
      lock_fields_q <= req_fields;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                          err_spurious <= 1'b0;
    else if (mem_data_ok && fifo_empty) err_spurious <= 1'b1;
  end

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)       prio_q <= SRC_DATA;
    else if (accept) prio_q <= (grant_src == SRC_DATA) ? SRC_INST : SRC_DATA;
  end
`endif

  arb_order_fifo #(.DEPTH(OUTSTANDING_DEPTH)) u_order_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .push_dat (grant_src),
    .pop      (pop),
    .pop_dat  (head_src),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: arbitration, lock, ordering, full FIFO, spurious responses.
// Inputs change 1ns after posedge; outputs are sampled 4ns after posedge.
module tb_sram_port_arbiter;

  logic        clk, reset;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, rdata;
  logic [3:0]  data_wstrb;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, err_spurious;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int errors = 0;
  int checks = 0;

  sram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .rdata(rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr = 32'h0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 32'h0;
    data_wstrb = 4'h0; data_wdata = 32'h0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    #3;
    if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    checks++;
    cyc();
    reset = 0;
    idle_inputs();
    #3;
    if (err_spurious !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b expected 0", err_spurious);
    end
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_idle_req: got %b expected 0", mem_req);
    end
    checks++;
    cyc();
  endtask

  task automatic test_priority();
    inst_req = 1; inst_addr = 32'h1000;
    data_req = 1; data_addr = 32'h2000; data_wr = 1; data_size = 2'd2;
    data_wstrb = 4'hf; data_wdata = 32'hdeadbeef; mem_addr_ok = 1;
    #3;
    if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL prio_grant: got %b expected 10", {data_addr_ok, inst_addr_ok});
    end
    checks++;
    if ({mem_wr, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 32'h2000, 4'hf, 32'hdeadbeef}) begin
      errors++; $display("FAIL prio_data_fields: got %b %h %h %h expected 1 2000 f deadbeef",
                         mem_wr, mem_addr, mem_wstrb, mem_wdata);
    end
    checks++;
    cyc();
    data_req = 0;
    #3;
    if ({data_addr_ok, inst_addr_ok} !== 2'b01) begin
      errors++; $display("FAIL prio_inst_next: got %b expected 01", {data_addr_ok, inst_addr_ok});
    end
    checks++;
    if ({mem_wr, mem_size, mem_addr, mem_wstrb} !== {1'b0, 2'd2, 32'h1000, 4'h0}) begin
      errors++; $display("FAIL prio_inst_fields: got %b %0d %h %h expected 0 2 1000 0",
                         mem_wr, mem_size, mem_addr, mem_wstrb);
    end
    checks++;
    cyc();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #3;
    if ({inst_data_ok, data_data_ok} !== 2'b01) begin
      errors++; $display("FAIL prio_resp0: got %b expected 01", {inst_data_ok, data_data_ok});
    end
    checks++;
    cyc();
    #3;
    if ({inst_data_ok, data_data_ok} !== 2'b10) begin
      errors++; $display("FAIL prio_resp1: got %b expected 10", {inst_data_ok, data_data_ok});
    end
    checks++;
    cyc();
    idle_inputs();
  endtask

  task automatic test_lock();
    data_req = 1; data_addr = 32'h100; data_wr = 0; mem_addr_ok = 0;
    for (int i = 0; i < 3; i++) begin
      #3;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 || data_addr_ok !== 1'b0) begin
        errors++; $display("FAIL lock_hold%0d: got req=%b addr=%h ok=%b expected 1 100 0",
                           i, mem_req, mem_addr, data_addr_ok);
      end
      checks++;
      cyc();
      data_addr = 32'h200;
    end
    mem_addr_ok = 1;
    #3;
    if (mem_addr !== 32'h100 || data_addr_ok !== 1'b1) begin
      errors++; $display("FAIL lock_accept: got addr=%h ok=%b expected 100 1", mem_addr, data_addr_ok);
    end
    checks++;
    cyc();
    data_req = 0; mem_addr_ok = 0;
    #3;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL lock_clear: got %b expected 0", mem_req);
    end
    checks++;
    mem_data_ok = 1;
    #1;
    if (data_data_ok !== 1'b1) begin
      errors++; $display("FAIL lock_resp: got %b expected 1", data_data_ok);
    end
    checks++;
    cyc();
    idle_inputs();
  endtask

  task automatic test_order();
    logic [2:0]  srcs;
    logic [31:0] rd [3];
    srcs = 3'b010;
    rd[0] = 32'hA0A0A0A0; rd[1] = 32'hB1B1B1B1; rd[2] = 32'hC2C2C2C2;
    mem_addr_ok = 1;
    for (int i = 0; i < 3; i++) begin
      inst_req = ~srcs[i]; data_req = srcs[i];
      cyc();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      mem_data_ok = 1; mem_rdata = rd[i];
      #3;
      if ({inst_data_ok, data_data_ok} !== {~srcs[i], srcs[i]} || rdata !== rd[i]) begin
        errors++; $display("FAIL order_resp%0d: got %b rdata=%h expected %b rdata=%h",
                           i, {inst_data_ok, data_data_ok}, rdata, {~srcs[i], srcs[i]}, rd[i]);
      end
      checks++;
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_full();
    data_req = 1; data_addr = 32'h300; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #3;
      if (data_addr_ok !== 1'b1) begin
        errors++; $display("FAIL full_fill%0d: got %b expected 1", i, data_addr_ok);
      end
      checks++;
      cyc();
    end
    #3;
    if (mem_req !== 1'b0 || data_addr_ok !== 1'b0) begin
      errors++; $display("FAIL full_block: got req=%b ok=%b expected 0 0", mem_req, data_addr_ok);
    end
    checks++;
    cyc();
    mem_data_ok = 1;
    #3;
    if (mem_req !== 1'b0 || data_addr_ok !== 1'b0 || data_data_ok !== 1'b1) begin
      errors++; $display("FAIL full_pop_same: got req=%b ok=%b dok=%b expected 0 0 1",
                         mem_req, data_addr_ok, data_data_ok);
    end
    checks++;
    cyc();
    mem_data_ok = 0;
    #3;
    if (mem_req !== 1'b1 || data_addr_ok !== 1'b1) begin
      errors++; $display("FAIL full_resume: got req=%b ok=%b expected 1 1", mem_req, data_addr_ok);
    end
    checks++;
    cyc();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #3;
      if (data_data_ok !== 1'b1 || err_spurious !== 1'b0) begin
        errors++; $display("FAIL full_drain%0d: got dok=%b err=%b expected 1 0", i, data_data_ok, err_spurious);
      end
      checks++;
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_spurious();
    mem_data_ok = 1;
    #3;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      errors++; $display("FAIL spur_dok: got %b expected 00", {inst_data_ok, data_data_ok});
    end
    checks++;
    cyc();
    mem_data_ok = 0;
    for (int i = 0; i < 2; i++) begin
      #3;
      if (err_spurious !== 1'b1) begin
        errors++; $display("FAIL spur_sticky%0d: got %b expected 1", i, err_spurious);
      end
      checks++;
      cyc();
    end
    reset = 1;
    cyc();
    reset = 0;
    #3;
    if (err_spurious !== 1'b0) begin
      errors++; $display("FAIL spur_reset: got %b expected 0", err_spurious);
    end
    checks++;
    // One accepted transaction is dropped by reset; its late response is spurious.
    inst_req = 1; mem_addr_ok = 1;
    cyc();
    idle_inputs();
    reset = 1;
    cyc();
    reset = 0; mem_data_ok = 1;
    #3;
    if (inst_data_ok !== 1'b0) begin
      errors++; $display("FAIL midreset_dok: got %b expected 0", inst_data_ok);
    end
    checks++;
    cyc();
    mem_data_ok = 0;
    #3;
    if (err_spurious !== 1'b1) begin
      errors++; $display("FAIL midreset_err: got %b expected 1", err_spurious);
    end
    checks++;
    reset = 1;
    cyc();
    reset = 0;
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_data;
`ifdef SRAM_ARB_RR_EN
    exp_data = 4'b0101;
`else
    exp_data = 4'b1111;
`endif
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #3;
      if ({data_addr_ok, inst_addr_ok} !== {exp_data[i], ~exp_data[i]}) begin
        errors++; $display("FAIL arb_grant%0d: got %b expected %b",
                           i, {data_addr_ok, inst_addr_ok}, {exp_data[i], ~exp_data[i]});
      end
      checks++;
      cyc();
    end
    idle_inputs();
    mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #3;
      if ({data_data_ok, inst_data_ok} !== {exp_data[i], ~exp_data[i]}) begin
        errors++; $display("FAIL arb_resp%0d: got %b expected %b",
                           i, {data_data_ok, inst_data_ok}, {exp_data[i], ~exp_data[i]});
      end
      checks++;
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_lock();
    test_order();
    test_full();
    test_spurious();
    test_arbitration();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter: OUTSTANDING_DEPTH, 4, maximum accepted-but-unanswered transactions (power of two, 2..8).
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 inst_req  input  1  fetch request valid (read-only requester).
REQ-005 inst_addr  input  32  fetch byte address.
REQ-006 inst_addr_ok  output  1  fetch request accepted this cycle.
REQ-007 inst_data_ok  output  1  fetch read data returned this cycle.
REQ-008 data_req  input  1  load/store request valid.
REQ-009 data_wr  input  1  1 = store, 0 = load.
REQ-010 data_size  input  2  0 = byte, 1 = half, 2 = word.
REQ-011 data_addr  input  32  load/store byte address.
REQ-012 data_wstrb  input  4  store byte enables.
REQ-013 data_wdata  input  32  store data.
REQ-014 data_addr_ok  output  1  load/store request accepted this cycle.
REQ-015 data_data_ok  output  1  load data / store completion this cycle.
REQ-016 rdata  output  32  mem_rdata forwarded to both requesters.
REQ-017 mem_req, mem_wr, mem_size[1:0], mem_addr[31:0], mem_wstrb[3:0], mem_wdata[31:0]  output  request to shared port; inst requests drive mem_wr=0, mem_size=2, mem_wstrb=0.
REQ-018 mem_addr_ok, mem_data_ok  input  1  shared-port accept / response; mem_rdata  input  32.
REQ-019 err_spurious  output  1  sticky: mem_data_ok received with no transaction outstanding.

Function
REQ-020 Request accepted iff mem_req & mem_addr_ok; selected requester's addr_ok = mem_addr_ok & grant; other addr_ok = 0.
REQ-021 Arbitration combinational when unlocked: data beats inst if both request.
REQ-022 mem_req asserted without mem_addr_ok sets lock; grant and all mem_* request fields held from the locked source until acceptance; lock clears on acceptance.
REQ-023 Each acceptance pushes source id (0 = inst, 1 = data) into an in-order FIFO of OUTSTANDING_DEPTH entries.
REQ-024 mem_data_ok pops head; the head's source gets data_ok = 1 for exactly that cycle; the other gets 0.
REQ-025 FIFO full: mem_req = 0 and both addr_ok = 0, even if a pop occurs the same cycle; acceptance resumes the cycle after.
REQ-026 Push and pop in the same cycle with FIFO not full: occupancy unchanged, order preserved.
REQ-027 mem_data_ok with FIFO empty: no data_ok asserted, no pointer change, err_spurious set until reset.
REQ-028 Latency: zero added cycles on request and response paths (pure combinational forwarding plus FIFO bookkeeping).
REQ-029 Requesters may drop req only after acceptance; arbiter does not cancel or discard outstanding transactions.

Reset
REQ-030 On reset: FIFO empty, pointers 0, lock 0, err_spurious 0, round-robin pointer favors data; mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok are 0 during the reset cycle.
REQ-031 Reset mid-transaction drops all outstanding entries; late mem_data_ok afterwards sets err_spurious.

Configuration
REQ-032 SRAM_ARB_RR_EN defined: round-robin arbitration; after each acceptance, priority moves to the other source; unlocked ties go to the prioritized source.
REQ-033 SRAM_ARB_RR_EN undefined: fixed data-over-inst priority per REQ-021.

Structure
REQ-034 Shared package holds source-id constants (SRC_INST, SRC_DATA), size encodings and the default OUTSTANDING_DEPTH.
REQ-035 Order FIFO is one sub-module arb_order_fifo (1-bit payload, full/empty, simultaneous push/pop).

Verification
REQ-036 inst_req and data_req together, mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0; next cycle inst accepted.
REQ-037 data_req addr 0x100, mem_addr_ok low 3 cycles, data_addr changed to 0x200 by the bench -> mem_addr stays 0x100 until accepted.
REQ-038 Accept inst, data, inst; 3 mem_data_ok pulses -> data_ok sequence inst, data, inst; rdata = mem_rdata each cycle.
REQ-039 4 acceptances with no response -> mem_req=0; one mem_data_ok -> mem_req re-asserts next cycle.
REQ-040 mem_data_ok with FIFO empty -> no data_ok asserted, err_spurious=1 until reset.
REQ-041 With SRAM_ARB_RR_EN, both requesting continuously, mem_addr_ok=1 -> grants alternate data, inst, data, inst.
